train_sequencer: RTL and testbench

Parametrised training-pass sequencer for the on-chip learning datapath. It runs an initial forward pass, then alternates backward and forward passes until the datapath reports convergence or an iteration limit is reached. Each pass steps through `LAYERS` layers: ascending on forward passes, descending on backward passes. Compared with the fixed three-pass controller, it adds a per-layer start/done handshake, an iteration limit, a per-layer watchdog timeout, abort, and restart from the end state.

---
 rtl/train_sequencer.sv | 128 ++++++++++++
 tb/tb_train_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/train_sequencer.sv
// train_sequencer: forward/backward training-pass sequencer with per-layer handshake, iteration limit and watchdog
module train_sequencer #(
    parameter int LAYERS = 2,
    parameter int ITER_W = 8,
    parameter int TO_W   = 10,
    localparam int LW    = (LAYERS > 1) ? $clog2(LAYERS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              init_i,
    input  logic              abort_i,
    input  logic [ITER_W-1:0] max_iter_i,
    input  logic              layer_done_i,
    input  logic              converged_i,
    output logic [1:0]        phase_o,
    output logic              first_pass_o,
    output logic [LW-1:0]     layer_o,
    output logic              layer_start_o,
    output logic              zero_loss_o,
    output logic              zero_final_o,
    output logic              zero_weight_update_o,
    output logic [ITER_W-1:0] iter_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FI   = 3'd1;
    localparam logic [2:0] S_FW   = 3'd2;
    localparam logic [2:0] S_BI   = 3'd3;
    localparam logic [2:0] S_BW   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;
    localparam logic [LW-1:0] LAST = LW'(LAYERS - 1);
    // last watchdog value before the terminal count of 2^TO_W-1
    localparam logic [TO_W-1:0] WD_END = ~TO_W'(1);

    logic [2:0]        state;
    logic [LW-1:0]     layer;
    logic [ITER_W-1:0] iter;
    logic              first_pass;
    logic [TO_W-1:0]   wdog;
    logic              last, limit, live, stop;

    assign last  = layer == LAST;
    assign limit = (max_iter_i != '0) && (iter >= max_iter_i);
    assign stop  = converged_i || limit;
    assign live  = en_i && !abort_i;

    assign zero_loss_o          = live && state == S_BW && layer_done_i && layer == '0;
    assign zero_final_o         = zero_loss_o;
    assign zero_weight_update_o = live && state == S_FW && layer_done_i && last && !first_pass && !stop;
    assign layer_start_o        = en_i && (state == S_FI || state == S_BI);

    assign busy_o       = state == S_FI || state == S_FW || state == S_BI || state == S_BW;
    assign done_o       = state == S_DONE;
    assign timeout_o    = state == S_ERR;
    assign phase_o      = state == S_IDLE ? 2'b00 :
                          (state == S_FI || state == S_FW) ? 2'b01 :
                          (state == S_BI || state == S_BW) ? 2'b10 : 2'b11;
    assign first_pass_o = first_pass;
    assign layer_o      = layer;
    assign iter_o       = iter;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            layer      <= '0;
            iter       <= '0;
            first_pass <= 1'b0;
            wdog       <= '0;
        end else if (en_i) begin
            if (abort_i) begin
                state      <= S_IDLE;
                layer      <= '0;
                iter       <= '0;
                first_pass <= 1'b0;
                wdog       <= '0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: if (init_i) begin
                        state      <= S_FI;
                        layer      <= '0;
                        iter       <= '0;
                        first_pass <= 1'b1;
                        wdog       <= '0;
                    end
                    S_FI: begin
                        state <= S_FW;
                        wdog  <= '0;
                    end
                    S_BI: begin
                        state <= S_BW;
                        wdog  <= '0;
                    end
                    S_FW: if (layer_done_i) begin
                        if (!last) begin
                            layer <= layer + LW'(1);
                            state <= S_FI;
                        end else if (first_pass) begin
                            first_pass <= 1'b0;
                            state      <= S_BI;
                        end else begin
                            state <= stop ? S_DONE : S_BI;
                        end
                    end else begin
                        state <= (wdog == WD_END) ? S_ERR : state;
                        wdog  <= wdog + TO_W'(1);
                    end
                    S_BW: if (layer_done_i) begin
                        if (layer != '0) begin
                            layer <= layer - LW'(1);
                            state <= S_BI;
                        end else begin
                            iter  <= (&iter) ? iter : iter + ITER_W'(1);
                            state <= S_FI;
                        end
                    end else begin
                        state <= (wdog == WD_END) ? S_ERR : state;
                        wdog  <= wdog + TO_W'(1);
                    end
                    default: state <= state;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_train_sequencer.sv
// tb_train_sequencer: directed-vector bench for train_sequencer with LAYERS=2, TO_W=4
module tb_train_sequencer;
    logic       clk_i = 1'b0;
    logic       rst_i, en_i, init_i, abort_i, layer_done_i, converged_i;
    logic [7:0] max_iter_i;
    logic [1:0] phase_o;
    logic       first_pass_o, layer_start_o, zero_loss_o, zero_final_o, zero_weight_update_o;
    logic [0:0] layer_o;
    logic [7:0] iter_o;
    logic       busy_o, done_o, timeout_o;
    int total = 0, bad = 0;
    int cnt_zl = 0, cnt_zf = 0, cnt_zwu = 0, cnt_st = 0;
    int s_zl, s_zwu, s_st;

    train_sequencer #(.LAYERS(2), .ITER_W(8), .TO_W(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .init_i(init_i), .abort_i(abort_i),
        .max_iter_i(max_iter_i), .layer_done_i(layer_done_i), .converged_i(converged_i),
        .phase_o(phase_o), .first_pass_o(first_pass_o), .layer_o(layer_o),
        .layer_start_o(layer_start_o), .zero_loss_o(zero_loss_o), .zero_final_o(zero_final_o),
        .zero_weight_update_o(zero_weight_update_o), .iter_o(iter_o), .busy_o(busy_o),
        .done_o(done_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        cnt_zl  <= cnt_zl + int'(zero_loss_o);
        cnt_zf  <= cnt_zf + int'(zero_final_o);
        cnt_zwu <= cnt_zwu + int'(zero_weight_update_o);
        cnt_st  <= cnt_st + int'(layer_start_o);
    end

    wire [18:0] all_o = {phase_o, first_pass_o, layer_o, layer_start_o, zero_loss_o, zero_final_o,
                         zero_weight_update_o, iter_o, busy_o, done_o, timeout_o};
    // {first_pass, phase, layer, start, zero_loss, zero_weight_update, iter[1:0]}
    wire [8:0] obs = {first_pass_o, phase_o, layer_o, layer_start_o, zero_loss_o,
                      zero_weight_update_o, iter_o[1:0]};
    logic [8:0] nom [1:21] = '{9'h150, 9'h140, 9'h170, 9'h160, 9'h0B0, 9'h0A0, 9'h090, 9'h088,
                               9'h051, 9'h041, 9'h071, 9'h065, 9'h0B1, 9'h0A1, 9'h091, 9'h089,
                               9'h052, 9'h042, 9'h072, 9'h062, 9'h0E2};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #2;
    endtask

    task automatic sample;
        @(negedge clk_i);
        #1;
    endtask

    task automatic run_until(input logic [1:0] ph, input logic l, input int n);
        int i = 0;
        for (i = 0; i < n; i++) begin
            tick;
            sample;
            if (phase_o == ph && layer_o == l && layer_start_o) break;
        end
        chk("run_bound", 32'(i < n), 1);
    endtask

    task automatic wait_done(input int n);
        for (int i = 0; i < n && !done_o; i++) begin
            tick;
            sample;
        end
        chk("done_bound", 32'(done_o), 1);
    endtask

    initial begin
        rst_i = 1; en_i = 1; init_i = 0; abort_i = 0; layer_done_i = 0; converged_i = 0; max_iter_i = 0;
        sample;
        chk("reset", all_o, 0);
        tick; rst_i = 0;
        sample;
        chk("idle", all_o, 0);
        tick; init_i = 1; layer_done_i = 1;
        sample;
        for (int c = 1; c <= 21; c++) begin
            tick; init_i = 0; converged_i = (c >= 13);
            sample;
            chk($sformatf("nom%0d", c), obs, nom[c]);
        end
        chk("nom_done", {done_o, busy_o, iter_o}, {2'b10, 8'd2});
        chk("nom_zf", cnt_zf, 2);
        chk("nom_zwu", cnt_zwu, 1);
        s_zl = cnt_zl; s_zwu = cnt_zwu;
        tick; init_i = 1; max_iter_i = 3; converged_i = 0;
        sample;
        tick; init_i = 0;
        sample;
        chk("lim_restart", {phase_o, iter_o}, {2'b01, 8'd0});
        wait_done(200);
        chk("lim_iter", iter_o, 3);
        chk("lim_zl", cnt_zl - s_zl, 3);
        chk("lim_zwu", cnt_zwu - s_zwu, 2);
        s_zl = cnt_zl; s_zwu = cnt_zwu;
        tick; init_i = 1; max_iter_i = 0; converged_i = 1;
        sample;
        tick; init_i = 0;
        sample;
        wait_done(100);
        chk("fp_iter", iter_o, 1);
        chk("fp_zl", cnt_zl - s_zl, 1);
        chk("fp_zwu", cnt_zwu - s_zwu, 0);
        tick; init_i = 1; converged_i = 0;
        sample;
        tick; init_i = 0;
        sample;
        run_until(2'b10, 1'b1, 50);
        for (int w = 1; w <= 15; w++) begin
            tick; layer_done_i = 0;
            sample;
        end
        chk("to_w15", {timeout_o, phase_o}, {1'b0, 2'b10});
        tick;
        sample;
        chk("to_err", {timeout_o, busy_o, phase_o}, {2'b10, 2'b11});
        tick; init_i = 1;
        sample;
        tick;
        sample;
        chk("to_init_ign", {timeout_o, phase_o}, 3'b111);
        tick; init_i = 0; abort_i = 1;
        sample;
        tick; abort_i = 0;
        sample;
        chk("to_abort", all_o, 0);
        s_st = cnt_st;
        tick; init_i = 1; layer_done_i = 1;
        sample;
        tick; init_i = 0; en_i = 0;
        sample;
        repeat (4) begin
            tick;
            sample;
        end
        chk("stall_st", cnt_st - s_st, 0);
        tick; en_i = 1;
        sample;
        chk("stall_issue", {phase_o, layer_o, layer_start_o}, {2'b01, 1'b0, 1'b1});
        chk("stall_st1", cnt_st - s_st, 1);
        run_until(2'b10, 1'b0, 50);
        for (int w = 0; w < 10; w++) begin
            tick; layer_done_i = 0;
            sample;
        end
        s_zl = cnt_zl;
        repeat (5) begin
            tick; en_i = 0; layer_done_i = 1;
            sample;
        end
        chk("stall_zl0", cnt_zl - s_zl, 0);
        tick; en_i = 1;
        sample;
        chk("stall_pulse", {zero_loss_o, zero_final_o, timeout_o}, 3'b110);
        tick;
        sample;
        chk("stall_after", {phase_o, iter_o}, {2'b01, 8'd1});
        chk("stall_zl1", cnt_zl - s_zl, 1);
        run_until(2'b10, 1'b1, 50);
        tick; abort_i = 1;
        sample;
        chk("ab1_pulse", {zero_loss_o, zero_final_o, zero_weight_update_o}, 0);
        tick; abort_i = 0;
        sample;
        chk("ab1_idle", all_o, 0);
        tick; init_i = 1;
        sample;
        tick; init_i = 0;
        sample;
        run_until(2'b10, 1'b0, 50);
        tick; abort_i = 1;
        sample;
        chk("ab0_pulse", {zero_loss_o, zero_final_o}, 0);
        tick; abort_i = 0;
        sample;
        chk("ab0_idle", all_o, 0);
        tick; init_i = 1;
        sample;
        tick; init_i = 0; layer_done_i = 0;
        sample;
        tick;
        sample;
        chk("rst_pre", {phase_o, busy_o}, 3'b011);
        rst_i = 1;
        #1;
        chk("rst_async", all_o, 0);
        tick; rst_i = 0;
        sample;
        tick; init_i = 1; layer_done_i = 1;
        sample;
        tick; init_i = 0;
        sample;
        chk("fresh", {phase_o, layer_o, layer_start_o, iter_o}, {2'b01, 1'b0, 1'b1, 8'd0});
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
